// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants for the GPIO pad controller
package gpio_pkg;
  localparam int GPIO_NPINS = 16;
  localparam int IRQ_RISE = 0;
  localparam int IRQ_FALL = 1;
  localparam int IRQ_BOTH = 2;
  localparam int GPIO_IRQ_LINE = 0;
endpackage

// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: register-file side of the GPIO controller
interface gpio_ctrl_if import gpio_pkg::*; #(parameter int N = GPIO_NPINS);
  logic [N-1:0] rf_gpio_datareg;
  logic [N-1:0] rf_gpio_tristate;
  logic [N-1:0] rf_gpio_interrupt_mask;
  logic [N-1:0] irq_clear;
  logic [N-1:0] ro_gpio_pinstate;
  logic [N-1:0] irq_pending;
  modport master (
    output rf_gpio_datareg, rf_gpio_tristate, rf_gpio_interrupt_mask, irq_clear,
    input ro_gpio_pinstate, irq_pending
  );
  modport slave (
    input rf_gpio_datareg, rf_gpio_tristate, rf_gpio_interrupt_mask, irq_clear,
    output ro_gpio_pinstate, irq_pending
  );
endinterface

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter: per-pin synchronizer, debounce filter and delayed filtered level
module gpio_pin_filter #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filt,
  output logic filt_d
);
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    sync_q <= reset ? 2'b00 : {sync_q[0], pin};
    filt_d <= reset ? 1'b0 : filt;
  end
  if (DEBOUNCE == 0) begin : g_byp
    always_ff @(posedge clk) filt <= reset ? 1'b0 : sync_q[1];
  end else begin : g_deb
    localparam int CW = $clog2(DEBOUNCE + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt  <= '0;
        filt <= 1'b0;
      end else if (sync_q[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt  <= '0;
        filt <= sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: GPIO pad controller with debounced inputs, edge pending bits and a level interrupt
module gpio_ctrl import gpio_pkg::*; #(
  parameter int NPINS = GPIO_NPINS,
  parameter int DEBOUNCE = 4,
  parameter int IRQ_EDGE = IRQ_RISE
) (
  input  logic             clk,
  input  logic             reset,
  gpio_ctrl_if.slave       rf,
  input  logic [NPINS-1:0] gpio_in,
  output logic [NPINS-1:0] gpio_out,
  output logic [NPINS-1:0] gpio_oe,
  output logic             gpio_irq
);
  localparam int ARM = 3 + DEBOUNCE;
  localparam int AW = $clog2(ARM + 1);
  logic [NPINS-1:0] filt, filt_d, evt, pend;
  logic [AW-1:0] arm_cnt;
  logic armed;
  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    gpio_pin_filter #(.DEBOUNCE(DEBOUNCE)) u_filt (
      .clk(clk),
      .reset(reset),
      .pin(gpio_in[i]),
      .filt(filt[i]),
      .filt_d(filt_d[i])
    );
  end
  always_comb begin
    evt = IRQ_EDGE == IRQ_RISE ? (filt & ~filt_d) :
          IRQ_EDGE == IRQ_FALL ? (~filt & filt_d) : (filt ^ filt_d);
  end
  assign gpio_out = rf.rf_gpio_datareg;
  assign gpio_oe = reset ? '0 : ~rf.rf_gpio_tristate;
  assign rf.ro_gpio_pinstate = filt;
  assign rf.irq_pending = pend;
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt  <= '0;
      armed    <= 1'b0;
      pend     <= '0;
      gpio_irq <= 1'b0;
    end else begin
      arm_cnt  <= armed ? arm_cnt : arm_cnt + 1'b1;
      armed    <= armed | (arm_cnt == AW'(ARM - 1));
      pend     <= (armed ? (evt & rf.rf_gpio_interrupt_mask) : '0) | (pend & ~rf.irq_clear);
      gpio_irq <= |(pend & rf.rf_gpio_interrupt_mask);
    end
  end
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed and random checks of gpio_ctrl against a windowed reference model
module tb_gpio_ctrl;
  import gpio_pkg::*;
  localparam int N = GPIO_NPINS;
  localparam int D = 4;
  localparam int ARM = 3 + D;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] gpio_in = '0;
  logic [N-1:0] gpio_out, gpio_oe;
  logic gpio_irq;
  logic [N-1:0] dat = '0, tri_s = '0, mask = '0, clr = '0;
  int total = 0;
  int bad = 0;
  logic [N-1:0] p1, p2, m_filt, m_filt_d, m_pend;
  logic [N-1:0] win [D];
  logic m_irq;
  int cyc;
  gpio_ctrl_if #(.N(N)) bus ();
  assign bus.rf_gpio_datareg = dat;
  assign bus.rf_gpio_tristate = tri_s;
  assign bus.rf_gpio_interrupt_mask = mask;
  assign bus.irq_clear = clr;
  gpio_ctrl #(.NPINS(N), .DEBOUNCE(D), .IRQ_EDGE(IRQ_RISE)) dut (
    .clk(clk),
    .reset(reset),
    .rf(bus.slave),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe(gpio_oe),
    .gpio_irq(gpio_irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  task automatic step();
    logic [N-1:0] chg;
    @(posedge clk);
    if (reset) begin
      p1 = '0;
      p2 = '0;
      for (int k = 0; k < D; k++) win[k] = '0;
      m_filt = '0;
      m_filt_d = '0;
      m_pend = '0;
      m_irq = 1'b0;
      cyc = 0;
    end else begin
      for (int k = D - 1; k > 0; k--) win[k] = win[k-1];
      win[0] = p2;
      chg = '1;
      for (int k = 0; k < D; k++) chg &= win[k] ^ m_filt;
      m_irq = |(m_pend & mask);
      m_pend = (m_pend & ~clr) | ((cyc >= ARM) ? (m_filt & ~m_filt_d & mask) : '0);
      m_filt_d = m_filt;
      m_filt = m_filt ^ chg;
      p2 = p1;
      p1 = gpio_in;
      cyc++;
    end
    #1;
    chk("pinstate", bus.ro_gpio_pinstate, m_filt);
    chk("pending", bus.irq_pending, m_pend);
    chk("irq", N'(gpio_irq), N'(m_irq));
    chk("out", gpio_out, dat);
    chk("oe", gpio_oe, reset ? '0 : ~tri_s);
  endtask
  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
  initial begin
    gpio_in = 16'hFFFF;
    steps(3);
    reset = 1'b0;
    steps(5);
    chk("startup_t5", bus.ro_gpio_pinstate, 16'h0000);
    step();
    chk("startup_t6", bus.ro_gpio_pinstate, 16'hFFFF);
    steps(6);
    chk("startup_nopend", bus.irq_pending, 16'h0000);
    gpio_in = 16'hFFFE;
    steps(8);
    mask = 16'h0001;
    gpio_in = 16'hFFFF;
    steps(5);
    chk("rise_t5", bus.ro_gpio_pinstate & 16'h0001, 16'h0000);
    step();
    chk("rise_t6", bus.ro_gpio_pinstate & 16'h0001, 16'h0001);
    chk("rise_t6_pend", bus.irq_pending, 16'h0000);
    step();
    chk("rise_t7_pend", bus.irq_pending, 16'h0001);
    chk("rise_t7_irq", N'(gpio_irq), 16'h0000);
    step();
    chk("rise_t8_irq", N'(gpio_irq), 16'h0001);
    gpio_in[3] = 1'b0;
    steps(8);
    mask = 16'h0009;
    gpio_in[3] = 1'b1;
    steps(3);
    gpio_in[3] = 1'b0;
    steps(8);
    chk("glitch_pin", bus.ro_gpio_pinstate & 16'h0008, 16'h0000);
    chk("glitch_pend", bus.irq_pending & 16'h0008, 16'h0000);
    gpio_in[0] = 1'b0;
    steps(8);
    gpio_in[0] = 1'b1;
    steps(6);
    clr = 16'h0001;
    step();
    clr = '0;
    chk("setwins_pend", bus.irq_pending & 16'h0001, 16'h0001);
    step();
    clr = 16'h0001;
    step();
    clr = '0;
    chk("clear_pend", bus.irq_pending, 16'h0000);
    chk("clear_irq_lag", N'(gpio_irq), 16'h0001);
    step();
    chk("clear_irq", N'(gpio_irq), 16'h0000);
    tri_s = 16'hFF00;
    dat = 16'hA5A5;
    #1;
    chk("dir_oe", gpio_oe, 16'h00FF);
    chk("dir_out", gpio_out, 16'hA5A5);
    reset = 1'b1;
    #1;
    chk("reset_oe", gpio_oe, 16'h0000);
    gpio_in = '0;
    mask = '0;
    steps(2);
    reset = 1'b0;
    steps(ARM + 3);
    gpio_in[5] = 1'b1;
    steps(10);
    chk("unmasked_pend", bus.irq_pending, 16'h0000);
    mask = 16'h0020;
    gpio_in[5] = 1'b0;
    steps(8);
    gpio_in[5] = 1'b1;
    steps(8);
    chk("pin5_pend", bus.irq_pending, 16'h0020);
    chk("pin5_irq", N'(gpio_irq), 16'h0001);
    mask = '0;
    step();
    chk("masked_irq", N'(gpio_irq), 16'h0000);
    chk("masked_keeps", bus.irq_pending, 16'h0020);
    mask = 16'h0020;
    step();
    chk("remask_irq", N'(gpio_irq), 16'h0001);
    for (int it = 0; it < 600; it++) begin
      reset = ($urandom % 60) == 0;
      if ($urandom % 6 == 0) gpio_in = gpio_in ^ N'($urandom & $urandom);
      if ($urandom % 20 == 0) mask = N'($urandom);
      if ($urandom % 25 == 0) tri_s = N'($urandom);
      dat = N'($urandom);
      clr = ($urandom % 5 == 0) ? N'($urandom) : '0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
